// File: rtl/logic_op_pkg.sv
// Shared types for the logic-op arbiter: opcode encoding and FSM states.
package logic_op_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

endpackage

// File: rtl/logic_unit.sv
// Shared combinational bitwise datapath: AND, OR, XOR, NAND on WIDTH-bit operands.
module logic_unit
  import logic_op_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    unique case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one logic_unit among NUM_REQ requesters;
// one transaction in flight at a time, result returned over a valid/ready channel.
module logic_op_arbiter
  import logic_op_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]      req_a,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]      req_b,
  input  logic [NUM_REQ-1:0][1:0]            req_op,
  output logic                               rsp_valid,
  input  logic                               rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]         rsp_id,
  output logic [WIDTH-1:0]                   rsp_y
);

  localparam int unsigned IdW = $clog2(NUM_REQ);

  state_e           state_q, state_d;
  logic [IdW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]   win_id;
  logic             found;
  logic             accept;
  logic [IdW-1:0]   id_q;
  logic [WIDTH-1:0] a_q, b_q, y_q;
  logic [WIDTH-1:0] unit_y;
  op_e              op_q;

  // Cyclic search starting at rr_ptr; first valid requester wins.
  always_comb begin
    int unsigned idx;
    found  = 1'b0;
    win_id = '0;
    idx    = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[IdW'(idx)]) begin
        found  = 1'b1;
        win_id = IdW'(idx);
      end
    end
  end

  assign accept = (state_q == IDLE) && found;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[win_id] = 1'b1;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = (win_id == IdW'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic_unit #(
    .WIDTH(WIDTH)
  ) u_logic_unit (
    .a (a_q),
    .b (b_q),
    .op(op_q),
    .y (unit_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_AND;
      y_q      <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      if (accept) begin
        id_q <= win_id;
        a_q  <= req_a[win_id];
        b_q  <= req_b[win_id];
        op_q <= op_e'(req_op[win_id]);
      end
      if (state_q == EXEC) y_q <= unit_y;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_y     = y_q;

endmodule
